// File: rtl/snake_mover.sv
// snake_mover: snake game logic feeding the renderer.
// Holds four segment coordinates on a 64x64 cell grid. Each frame tick
// advances the snake one cell in the selected direction. Wall and self
// collisions are detected, and the block sequences idle, run and game-over.
//
// Ports
//   clk                  system clock (posedge)
//   rst_n                asynchronous active-low reset (reloads start image)
//   tick                 one-cycle frame-step strobe
//   btn_up/down/left/right  debounced direction levels (up > down > left > right)
//   pause                freezes stepping while running
//   Px1..Px4, Py1..Py4   segment coordinates, 1 = head, 4 = tail
//   AllBlack             high while in game-over (screen blanked)
//   alive                high while running
//
// Build option
//   SNAKE_WRAP_EN        when defined, the grid edges wrap and only self
//                        collision ends the game. When undefined, stepping off
//                        any edge is lethal.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | start image shown, waiting for any button
// S_RUN  | stepping one cell per unpaused tick
// S_DEAD | frozen and blanked; leaves after DEAD_TICKS ticks

module snake_mover #(
    parameter int unsigned START_X    = 32,
    parameter int unsigned START_Y    = 32,
    parameter int unsigned DEAD_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       pause,
    output logic [5:0] Px1,
    output logic [5:0] Px2,
    output logic [5:0] Px3,
    output logic [5:0] Px4,
    output logic [5:0] Py1,
    output logic [5:0] Py2,
    output logic [5:0] Py3,
    output logic [5:0] Py4,
    output logic       AllBlack,
    output logic       alive
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam int CNT_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_TICKS - 1);

    localparam logic [5:0] SX = START_X[5:0];
    localparam logic [5:0] SY = START_Y[5:0];
    // Index 0 is the head; the body trails to the left of the head.
    localparam logic [3:0][5:0] INIT_X = {SX - 6'd3, SX - 6'd2, SX - 6'd1, SX};
    localparam logic [3:0][5:0] INIT_Y = {SY, SY, SY, SY};

    state_t           state_q, state_d;
    dir_t             cur_dir_q, cur_dir_d;
    dir_t             next_dir_q, next_dir_d;
    logic [3:0][5:0]  xs_q, xs_d;
    logic [3:0][5:0]  ys_q, ys_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       press_vld;
    dir_t       press_dir;
    dir_t       ref_dir;
    logic [5:0] cand_x, cand_y;
    logic       self_hit, collide, step_go, step_ok;

    function automatic dir_t reverse_dir(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    always_comb begin
        press_vld = btn_up | btn_down | btn_left | btn_right;
        if (btn_up)        press_dir = DIR_UP;
        else if (btn_down) press_dir = DIR_DOWN;
        else if (btn_left) press_dir = DIR_LEFT;
        else               press_dir = DIR_RIGHT;
    end

    always_comb begin
        cand_x = xs_q[0];
        cand_y = ys_q[0];
        case (next_dir_q)
            DIR_UP:   cand_y = ys_q[0] - 6'd1;
            DIR_DOWN: cand_y = ys_q[0] + 6'd1;
            DIR_LEFT: cand_x = xs_q[0] - 6'd1;
            default:  cand_x = xs_q[0] + 6'd1;
        endcase
    end

    // The tail cell is vacated by the same step, so only seg2/seg3 count.
    assign self_hit = ((cand_x == xs_q[1]) && (cand_y == ys_q[1])) ||
                      ((cand_x == xs_q[2]) && (cand_y == ys_q[2]));

`ifdef SNAKE_WRAP_EN
    assign collide = self_hit;
`else
    logic wall_hit;
    always_comb begin
        wall_hit = 1'b0;
        case (next_dir_q)
            DIR_UP:   wall_hit = (ys_q[0] == 6'd0);
            DIR_DOWN: wall_hit = (ys_q[0] == 6'd63);
            DIR_LEFT: wall_hit = (xs_q[0] == 6'd0);
            default:  wall_hit = (xs_q[0] == 6'd63);
        endcase
    end
    assign collide = self_hit | wall_hit;
`endif

    assign step_go = (state_q == S_RUN) && tick && !pause;
    assign step_ok = step_go && !collide;
    // On a stepping cycle the pending direction becomes current, so a press
    // is checked against the direction the snake is about to travel.
    assign ref_dir = step_ok ? next_dir_q : cur_dir_q;

    always_comb begin
        state_d    = state_q;
        cur_dir_d  = cur_dir_q;
        next_dir_d = next_dir_q;
        xs_d       = xs_q;
        ys_d       = ys_q;
        cnt_d      = cnt_q;

        if (press_vld && (press_dir != reverse_dir(ref_dir))) begin
            next_dir_d = press_dir;
        end

        case (state_q)
            S_IDLE: begin
                if (press_vld) state_d = S_RUN;
            end
            S_RUN: begin
                if (step_go) begin
                    if (collide) begin
                        state_d = S_DEAD;
                        cnt_d   = '0;
                    end else begin
                        xs_d      = {xs_q[2:0], cand_x};
                        ys_d      = {ys_q[2:0], cand_y};
                        cur_dir_d = next_dir_q;
                    end
                end
            end
            S_DEAD: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d    = S_IDLE;
                        xs_d       = INIT_X;
                        ys_d       = INIT_Y;
                        cur_dir_d  = DIR_RIGHT;
                        next_dir_d = DIR_RIGHT;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_dir_q  <= DIR_RIGHT;
            next_dir_q <= DIR_RIGHT;
            xs_q       <= INIT_X;
            ys_q       <= INIT_Y;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_dir_q  <= cur_dir_d;
            next_dir_q <= next_dir_d;
            xs_q       <= xs_d;
            ys_q       <= ys_d;
            cnt_q      <= cnt_d;
        end
    end

    assign Px1 = xs_q[0];
    assign Px2 = xs_q[1];
    assign Px3 = xs_q[2];
    assign Px4 = xs_q[3];
    assign Py1 = ys_q[0];
    assign Py2 = ys_q[1];
    assign Py3 = ys_q[2];
    assign Py4 = ys_q[3];
    assign AllBlack = (state_q == S_DEAD);
    assign alive    = (state_q == S_RUN);

endmodule

// File: tb/tb_snake_mover.sv
// Testbench for snake_mover: directed vector table, hand sequences for wall,
// game-over, pause and async reset, then random stimulus against a model.
module tb_snake_mover;

    localparam int SX = 32;
    localparam int SY = 32;
    localparam int DEAD_TICKS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic pause = 1'b0;
    logic [5:0] Px1, Px2, Px3, Px4, Py1, Py2, Py3, Py4;
    logic AllBlack, alive;

    always #5 clk = ~clk;

    snake_mover #(.START_X(SX), .START_Y(SY), .DEAD_TICKS(DEAD_TICKS)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .pause(pause),
        .Px1(Px1), .Px2(Px2), .Px3(Px3), .Px4(Px4),
        .Py1(Py1), .Py2(Py2), .Py3(Py3), .Py4(Py4),
        .AllBlack(AllBlack), .alive(alive)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain integer coordinates, direction as (dx,dy) deltas.
    int mx[4];
    int my[4];
    int m_state;          // 0 idle, 1 running, 2 game over
    int m_cdx, m_cdy;     // last step direction
    int m_ndx, m_ndy;     // pending direction
    int m_cnt;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mx[k] = (SX - k + 64) % 64;
            my[k] = SY;
        end
        m_state = 0;
        m_cdx = 1; m_cdy = 0;
        m_ndx = 1; m_ndy = 0;
        m_cnt = 0;
    endtask

    task automatic model_step(input logic [3:0] b, input logic tk, input logic ps);
        int pdx, pdy, rdx, rdy, cx, cy;
        bit pv, hit, reloaded;
        pdx = 0; pdy = 0; reloaded = 0;
        pv = (b != 4'b0);
        if (b[3])      pdy = -1;
        else if (b[2]) pdy = 1;
        else if (b[1]) pdx = -1;
        else if (b[0]) pdx = 1;
        rdx = m_cdx; rdy = m_cdy;
        if (m_state == 0) begin
            if (pv) m_state = 1;
        end else if (m_state == 1) begin
            if (tk && !ps) begin
                cx = mx[0] + m_ndx;
                cy = my[0] + m_ndy;
                hit = 0;
`ifdef SNAKE_WRAP_EN
                cx = (cx + 64) % 64;
                cy = (cy + 64) % 64;
`else
                if (cx < 0 || cx > 63 || cy < 0 || cy > 63) hit = 1;
`endif
                for (int k = 1; k <= 2; k++)
                    if (cx == mx[k] && cy == my[k]) hit = 1;
                if (hit) begin
                    m_state = 2;
                    m_cnt = 0;
                end else begin
                    for (int k = 3; k >= 1; k--) begin
                        mx[k] = mx[k-1];
                        my[k] = my[k-1];
                    end
                    mx[0] = cx; my[0] = cy;
                    m_cdx = m_ndx; m_cdy = m_ndy;
                    rdx = m_ndx; rdy = m_ndy;
                end
            end
        end else begin
            if (tk) begin
                m_cnt++;
                if (m_cnt == DEAD_TICKS) begin
                    model_reset();
                    reloaded = 1;
                end
            end
        end
        if (pv && !reloaded && !(pdx == -rdx && pdy == -rdy)) begin
            m_ndx = pdx; m_ndy = pdy;
        end
    endtask

    // One clock: inputs stable before the edge, model follows, sample 1ns after.
    task automatic cycle(input logic [3:0] b, input logic tk, input logic ps);
        {btn_up, btn_down, btn_left, btn_right} = b;
        tick = tk;
        pause = ps;
        @(posedge clk);
        model_step(b, tk, ps);
        #1;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0;
        tick = 1'b0;
        pause = 1'b0;
    endtask

    task automatic check_fixed(input string name, input int hx, input int hy,
                               input int tx, input int ty, input logic al, input logic bl);
        n_tests++;
        if (Px1 !== 6'(hx) || Py1 !== 6'(hy) || Px4 !== 6'(tx) || Py4 !== 6'(ty) ||
            alive !== al || AllBlack !== bl) begin
            n_fail++;
            $display("FAIL %s: got head(%0d,%0d) tail(%0d,%0d) alive=%b black=%b, want head(%0d,%0d) tail(%0d,%0d) alive=%b black=%b",
                     name, Px1, Py1, Px4, Py4, alive, AllBlack, hx, hy, tx, ty, al, bl);
        end
    endtask

    task automatic check_model(input string name);
        logic [5:0] ex[4];
        logic [5:0] ey[4];
        for (int k = 0; k < 4; k++) begin
            ex[k] = 6'(mx[k]);
            ey[k] = 6'(my[k]);
        end
        n_tests++;
        if (Px1 !== ex[0] || Px2 !== ex[1] || Px3 !== ex[2] || Px4 !== ex[3] ||
            Py1 !== ey[0] || Py2 !== ey[1] || Py3 !== ey[2] || Py4 !== ey[3] ||
            alive !== (m_state == 1) || AllBlack !== (m_state == 2)) begin
            n_fail++;
            $display("FAIL %s @%0t: got x=%0d,%0d,%0d,%0d y=%0d,%0d,%0d,%0d alive=%b black=%b, want x=%0d,%0d,%0d,%0d y=%0d,%0d,%0d,%0d alive=%b black=%b",
                     name, $time, Px1, Px2, Px3, Px4, Py1, Py2, Py3, Py4, alive, AllBlack,
                     ex[0], ex[1], ex[2], ex[3], ey[0], ey[1], ey[2], ey[3],
                     (m_state == 1), (m_state == 2));
        end
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_fixed("async_reset_image", SX, SY, SX - 3, SY, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] btn;   // {up, down, left, right}
        logic       tk;
        logic       ps;
        int         hx, hy, tx, ty;
        logic       al, bl;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{4'b0001, 1'b0, 1'b0, 32, 32, 29, 32, 1'b1, 1'b0}; // start
        vecs[1]  = '{4'b0000, 1'b1, 1'b0, 33, 32, 30, 32, 1'b1, 1'b0};
        vecs[2]  = '{4'b0000, 1'b1, 1'b0, 34, 32, 31, 32, 1'b1, 1'b0};
        vecs[3]  = '{4'b0000, 1'b1, 1'b0, 35, 32, 32, 32, 1'b1, 1'b0};
        vecs[4]  = '{4'b0010, 1'b0, 1'b0, 35, 32, 32, 32, 1'b1, 1'b0}; // reverse rejected
        vecs[5]  = '{4'b0000, 1'b1, 1'b0, 36, 32, 33, 32, 1'b1, 1'b0};
        vecs[6]  = '{4'b1000, 1'b0, 1'b0, 36, 32, 33, 32, 1'b1, 1'b0};
        vecs[7]  = '{4'b0000, 1'b1, 1'b0, 36, 31, 34, 32, 1'b1, 1'b0};
        vecs[8]  = '{4'b0100, 1'b1, 1'b0, 36, 30, 35, 32, 1'b1, 1'b0}; // tick+down
        vecs[9]  = '{4'b0000, 1'b1, 1'b0, 36, 29, 36, 32, 1'b1, 1'b0}; // still up
        vecs[10] = '{4'b0000, 1'b1, 1'b1, 36, 29, 36, 32, 1'b1, 1'b0}; // paused
        vecs[11] = '{4'b1010, 1'b0, 1'b0, 36, 29, 36, 32, 1'b1, 1'b0}; // up wins
        vecs[12] = '{4'b0010, 1'b0, 1'b0, 36, 29, 36, 32, 1'b1, 1'b0};
        vecs[13] = '{4'b0000, 1'b1, 1'b0, 35, 29, 36, 31, 1'b1, 1'b0};

        model_reset();
        rst_n = 1'b0;
        #12;
        check_fixed("reset_image", SX, SY, SX - 3, SY, 1'b0, 1'b0);
        check_model("reset_model");
        rst_n = 1'b1;
        #2;

        // No movement in IDLE even with ticks.
        cycle(4'b0000, 1'b1, 1'b0);
        check_fixed("idle_no_move", 32, 32, 29, 32, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].btn, vecs[i].tk, vecs[i].ps);
            check_fixed($sformatf("vec%0d", i), vecs[i].hx, vecs[i].hy,
                        vecs[i].tx, vecs[i].ty, vecs[i].al, vecs[i].bl);
        end
        check_model("table_end_model");

        // Wall sequence: run right until x=63, then one more step.
        async_reset();
        cycle(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) cycle(4'b0000, 1'b1, 1'b0);
        check_fixed("at_x63", 63, 32, 60, 32, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
`ifdef SNAKE_WRAP_EN
        check_fixed("wrap_x0", 0, 32, 61, 32, 1'b1, 1'b0);
        check_model("wrap_model");
`else
        check_fixed("wall_hit", 63, 32, 60, 32, 1'b0, 1'b1);
        // Pause and buttons have no effect on the dead countdown.
        for (int i = 0; i < DEAD_TICKS - 1; i++) begin
            cycle(4'b0100, 1'b1, 1'b1);
            cycle(4'b0000, 1'b0, 1'b0);
        end
        check_fixed("dead_before_last", 63, 32, 60, 32, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b1);
        check_fixed("dead_exit_image", 32, 32, 29, 32, 1'b0, 1'b0);
        check_model("dead_exit_model");
        cycle(4'b0000, 1'b1, 1'b0);
        check_fixed("idle_after_dead", 32, 32, 29, 32, 1'b0, 1'b0);
`endif

        // Pause sequence, then reset asserted between edges mid-run.
        async_reset();
        cycle(4'b0001, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(4'b0000, 1'b1, 1'b1);
        check_fixed("pause_static", 33, 32, 30, 32, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        check_fixed("after_pause", 34, 32, 31, 32, 1'b1, 1'b0);
        async_reset();

        // Random stimulus against the model.
        for (int i = 0; i < 6000; i++) begin
            logic [3:0] b;
            logic tk, ps;
            b  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            tk = ($urandom_range(0, 1) == 0);
            ps = ($urandom_range(0, 9) == 0);
            cycle(b, tk, ps);
            check_model("random");
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
